i2c_master_wr: RTL and testbench

- I2C write initiator, the transmitting end of the bus that the I2C monitor sniffs.
- Generates START, 7-bit address + W, one or more data bytes, checks ACK after each byte, then issues STOP.
- Used as an on-board traffic source and self-test stimulus for the monitor path.
- Drives SCL/SDA as open-drain enables; top-level pads implement the tri-state.

---
 rtl/i2c_master_wr.sv | 178 +++++++++++++++++
 tb/tb_i2c_master_wr.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// I2C write initiator: START, 7-bit address + W, data bytes with ACK check, STOP.
// SCL/SDA are open-drain enables; one bit slot is four quarters of QUARTER_CNT clocks.
module i2c_master_wr #(
    parameter int QUARTER_CNT = 60
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_start,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_sda,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_data_req,
    output logic       o_done,
    output logic       o_nack
);

    localparam int CW = (QUARTER_CNT > 1) ? $clog2(QUARTER_CNT) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic [2:0]    state;
    logic [1:0]    phase;
    logic [CW-1:0] qcnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    data_q;
    logic          last_q;
    logic          is_data;
    logic          sda_meta;
    logic          sda_sync;
    logic          busy;
    logic          data_req;
    logic          done;
    logic          nack;
    logic          scl_oe;
    logic          sda_oe;

    logic quarter_end;
    logic slot_end;

    assign quarter_end = (qcnt == CW'(QUARTER_CNT - 1));
    assign slot_end    = quarter_end && (phase == 2'd3);

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            qcnt     <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            data_q   <= 8'd0;
            last_q   <= 1'b0;
            is_data  <= 1'b0;
            sda_meta <= 1'b0;
            sda_sync <= 1'b0;
            busy     <= 1'b0;
            data_req <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            sda_meta <= i_sda;
            sda_sync <= sda_meta;
            data_req <= 1'b0;
            done     <= 1'b0;

            if (state == ST_IDLE) begin
                if (i_start) begin
                    state   <= ST_START;
                    phase   <= 2'd0;
                    qcnt    <= '0;
                    busy    <= 1'b1;
                    nack    <= 1'b0;
                    shift   <= {i_addr, 1'b0};
                    data_q  <= i_data;
                    last_q  <= i_last;
                    is_data <= 1'b0;
                end
            end else begin
                qcnt <= quarter_end ? '0 : qcnt + CW'(1);
                if (quarter_end) begin
                    phase <= phase + 2'd1;
                end

                if (slot_end) begin
                    case (state)
                        ST_START: begin
                            state   <= ST_BIT;
                            bit_cnt <= 3'd7;
                        end
                        ST_BIT: begin
                            shift <= {shift[6:0], 1'b0};
                            if (bit_cnt == 3'd0) begin
                                state    <= ST_ACK;
                                // lands on the first cycle of the ACK slot
                                data_req <= is_data && !last_q;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                        ST_ACK: begin
                            if (sda_sync) begin
                                nack  <= 1'b1;
                                state <= ST_STOP;
                            end else if (!is_data) begin
                                shift   <= data_q;
                                is_data <= 1'b1;
                                state   <= ST_BIT;
                                bit_cnt <= 3'd7;
                            end else if (last_q) begin
                                state <= ST_STOP;
                            end else begin
                                shift   <= i_data;
                                last_q  <= i_last;
                                state   <= ST_BIT;
                                bit_cnt <= 3'd7;
                            end
                        end
                        ST_STOP: begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            qcnt  <= '0;
                            phase <= 2'd0;
                        end
                        default: begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // SCL is held low for the first half of every data/ACK/STOP slot so SDA only moves then.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            ST_START: begin
                scl_oe = (phase == 2'd3);
                sda_oe = (phase != 2'd0);
            end
            ST_BIT: begin
                scl_oe = ~phase[1];
                sda_oe = ~shift[7];
            end
            ST_ACK: begin
                scl_oe = ~phase[1];
                sda_oe = 1'b0;
            end
            ST_STOP: begin
                scl_oe = ~phase[1];
                sda_oe = (phase != 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign o_scl_oe   = scl_oe;
    assign o_sda_oe   = sda_oe;
    assign o_busy     = busy;
    assign o_data_req = data_req;
    assign o_done     = done;
    assign o_nack     = nack;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: quarter-level waveform model, bus-decoding slave, directed and random writes.
module tb_i2c_master_wr;

    localparam int Q = 60;

    logic       i_clk;
    logic       i_res;
    logic       i_start;
    logic [6:0] i_addr;
    logic [7:0] i_data;
    logic       i_last;
    logic       i_sda;
    logic       o_scl_oe;
    logic       o_sda_oe;
    logic       o_busy;
    logic       o_data_req;
    logic       o_done;
    logic       o_nack;

    i2c_master_wr #(.QUARTER_CNT(Q)) dut (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_start    (i_start),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_last     (i_last),
        .i_sda      (i_sda),
        .o_scl_oe   (o_scl_oe),
        .o_sda_oe   (o_sda_oe),
        .o_busy     (o_busy),
        .o_data_req (o_data_req),
        .o_done     (o_done),
        .o_nack     (o_nack)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Open-drain bus slave: decodes bytes on SCL rising edges and drives ACK unless told to NACK.
    logic       pull;
    logic       prev_scl;
    logic       prev_sda;
    logic [7:0] sh;
    int         bitcnt;
    int         byte_idx;
    int         dec_cnt;
    logic [7:0] dec_mem [0:15];
    int         slave_nack;
    logic       scl_b;

    assign i_sda = ~(o_sda_oe | pull);
    assign scl_b = ~o_scl_oe;

    always @(posedge i_clk) begin
        if (i_res) begin
            prev_scl <= 1'b1;
            prev_sda <= 1'b1;
            bitcnt   <= 0;
            byte_idx <= 0;
            pull     <= 1'b0;
            dec_cnt  <= 0;
            sh       <= 8'd0;
        end else begin
            prev_scl <= scl_b;
            prev_sda <= i_sda;
            if (scl_b && prev_scl && prev_sda && !i_sda) begin
                bitcnt   <= 0;
                byte_idx <= 0;
                pull     <= 1'b0;
                dec_cnt  <= 0;
            end else if (scl_b && prev_scl && !prev_sda && i_sda) begin
                bitcnt <= 0;
            end else if (scl_b && !prev_scl) begin
                if (bitcnt < 8) sh <= {sh[6:0], i_sda};
                bitcnt <= bitcnt + 1;
            end else if (!scl_b && prev_scl) begin
                if (bitcnt == 8) begin
                    if (dec_cnt < 16) dec_mem[dec_cnt] <= sh;
                    dec_cnt <= dec_cnt + 1;
                    pull    <= (byte_idx != slave_nack);
                end else if (bitcnt == 9) begin
                    pull     <= 1'b0;
                    bitcnt   <= 0;
                    byte_idx <= byte_idx + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       busy;
        logic       req;
        logic       done;
        logic       nack;
        logic [1:0] kind;   // 1 = START q1, 2 = STOP q3 (legal SDA moves with SCL released)
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_bytes [0:3];
    logic       last_nack;
    logic       prev_scl_oe;
    logic       prev_sda_oe;
    int         checks;
    int         errors;
    int         cyc;

    task automatic push_q(input logic scl, input logic sda, input logic req,
                          input logic nk, input logic [1:0] kind);
        for (int c = 0; c < Q; c++) begin
            exp_t e;
            e.scl  = scl;
            e.sda  = sda;
            e.busy = 1'b1;
            e.req  = req && (c == 0);
            e.done = 1'b0;
            e.nack = nk;
            e.kind = kind;
            exp_q.push_back(e);
        end
    endtask

    // Expected per-cycle outputs of one whole transaction, built quarter by quarter.
    task automatic model_txn(input logic [6:0] a, input int n, input int nk);
        logic [7:0] b;
        logic       nv;
        logic       stop_now;
        exp_t       e;
        nv = 1'b0;
        stop_now = 1'b0;
        push_q(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        push_q(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        push_q(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        push_q(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k <= n; k++) begin
            if (!stop_now) begin
                b = (k == 0) ? {a, 1'b0} : tx_bytes[k-1];
                for (int i = 7; i >= 0; i--) begin
                    push_q(1'b1, ~b[i], 1'b0, 1'b0, 2'd0);
                    push_q(1'b1, ~b[i], 1'b0, 1'b0, 2'd0);
                    push_q(1'b0, ~b[i], 1'b0, 1'b0, 2'd0);
                    push_q(1'b0, ~b[i], 1'b0, 1'b0, 2'd0);
                end
                push_q(1'b1, 1'b0, (k >= 1) && (k < n), 1'b0, 2'd0);
                push_q(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                push_q(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
                push_q(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
                if (k == nk) begin
                    nv = 1'b1;
                    stop_now = 1'b1;
                end
            end
        end
        push_q(1'b1, 1'b1, 1'b0, nv, 2'd0);
        push_q(1'b1, 1'b1, 1'b0, nv, 2'd0);
        push_q(1'b0, 1'b1, 1'b0, nv, 2'd0);
        push_q(1'b0, 1'b0, 1'b0, nv, 2'd2);
        e = '{scl: 1'b0, sda: 1'b0, busy: 1'b0, req: 1'b0, done: 1'b1, nack: nv, kind: 2'd0};
        exp_q.push_back(e);
    endtask

    task automatic compare_cycle();
        exp_t       e;
        logic [5:0] got;
        logic [5:0] want;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{scl: 1'b0, sda: 1'b0, busy: 1'b0, req: 1'b0, done: 1'b0, nack: last_nack, kind: 2'd0};
        last_nack = e.nack;
        got  = {o_scl_oe, o_sda_oe, o_busy, o_data_req, o_done, o_nack};
        want = {e.scl, e.sda, e.busy, e.req, e.done, e.nack};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL outputs cycle %0d scl,sda,busy,req,done,nack got %b want %b", cyc, got, want);
        end
        if (!o_scl_oe && !prev_scl_oe && (o_sda_oe != prev_sda_oe)) begin
            checks++;
            if (!((e.kind == 2'd1 && o_sda_oe) || (e.kind == 2'd2 && !o_sda_oe))) begin
                errors++;
                $display("FAIL protocol cycle %0d sda_oe moved to %b with scl released", cyc, o_sda_oe);
            end
        end
        prev_scl_oe = o_scl_oe;
        prev_sda_oe = o_sda_oe;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        compare_cycle();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic start_txn(input logic [6:0] a, input int n, input int nk);
        i_addr     = a;
        i_data     = tx_bytes[0];
        i_last     = (n == 1);
        i_start    = 1'b1;
        slave_nack = nk;
        model_txn(a, n, nk);
        tick();
        i_start = 1'b0;
        i_addr  = 7'($urandom);
        i_data  = 8'($urandom);
        i_last  = 1'($urandom);
    endtask

    task automatic finish_txn(input int n, input int dly, input int inj_at,
                              output int dur, output int reqs);
        int   pend;
        logic got_done;
        dur = 0;
        reqs = 0;
        pend = -1;
        got_done = 1'b0;
        while (!got_done && dur < 20000) begin
            tick();
            dur++;
            if (dur == inj_at) begin
                i_start = 1'b1;
                i_addr  = 7'($urandom);
                i_data  = 8'($urandom);
                i_last  = 1'($urandom);
            end else begin
                i_start = 1'b0;
            end
            if (o_data_req) begin
                reqs++;
                pend = dly;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && reqs < 4) begin
                    i_data = tx_bytes[reqs];
                    i_last = (reqs == n - 1);
                end
            end
            if (o_done) got_done = 1'b1;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no o_done within %0d cycles", dur);
        end
    endtask

    task automatic check_decoded(input logic [6:0] a, input int n, input int nk);
        int sent;
        sent = (nk < 0) ? n + 1 : nk + 1;
        chk("decoded_count", 32'(dec_cnt), 32'(sent));
        for (int k = 0; k < sent && k < 16; k++) begin
            chk("decoded_byte", 32'(dec_mem[k]), (k == 0) ? 32'({a, 1'b0}) : 32'(tx_bytes[k-1]));
        end
    endtask

    int dur;
    int reqs;

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        last_nack = 1'b0;
        prev_scl_oe = 1'b0;
        prev_sda_oe = 1'b0;
        slave_nack = -1;
        i_res = 1'b1;
        i_start = 1'b0;
        i_addr = 7'd0;
        i_data = 8'd0;
        i_last = 1'b0;
        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'd0;

        // reset, idle, then reset in the middle of a data bit
        repeat (5) tick();
        i_res = 1'b0;
        repeat (100) tick();
        chk("idle_outputs", 32'({o_scl_oe, o_sda_oe, o_busy, o_done, o_nack}), 32'd0);
        tx_bytes[0] = 8'h96;
        start_txn(7'h3C, 1, -1);
        repeat (5 * Q + 5) tick();
        chk("mid_bit_scl_low", 32'(o_scl_oe), 32'd1);
        #1;
        i_res = 1'b1;
        exp_q.delete();
        last_nack = 1'b0;
        #1;
        chk("async_reset_release", 32'({o_scl_oe, o_sda_oe, o_busy}), 32'd0);
        repeat (3) tick();
        i_res = 1'b0;
        repeat (20) tick();

        // single byte write
        tx_bytes[0] = 8'hA5;
        start_txn(7'h50, 1, -1);
        finish_txn(1, 10, 0, dur, reqs);
        chk("single_duration", 32'(dur), 32'd4800);
        chk("single_reqs", 32'(reqs), 32'd0);
        chk("single_nack", 32'(o_nack), 32'd0);
        chk("single_dec_count", 32'(dec_cnt), 32'd2);
        chk("single_dec_addr", 32'(dec_mem[0]), 32'hA0);
        chk("single_dec_data", 32'(dec_mem[1]), 32'hA5);
        repeat (10) tick();

        // address NACK
        tx_bytes[0] = 8'h5A;
        start_txn(7'h2B, 1, 0);
        finish_txn(1, 10, 0, dur, reqs);
        chk("nack_duration", 32'(dur), 32'd2640);
        chk("nack_flag", 32'(o_nack), 32'd1);
        chk("nack_dec_count", 32'(dec_cnt), 32'd1);
        chk("nack_dec_addr", 32'(dec_mem[0]), 32'h56);
        repeat (20) tick();
        chk("nack_sticky", 32'(o_nack), 32'd1);

        // three byte burst
        tx_bytes[0] = 8'h11;
        tx_bytes[1] = 8'h22;
        tx_bytes[2] = 8'h33;
        start_txn(7'h21, 3, -1);
        chk("nack_cleared_on_start", 32'(o_nack), 32'd0);
        finish_txn(3, 10, 0, dur, reqs);
        chk("burst_duration", 32'(dur), 32'd9120);
        chk("burst_reqs", 32'(reqs), 32'd2);
        chk("burst_dec_count", 32'(dec_cnt), 32'd4);
        chk("burst_dec_addr", 32'(dec_mem[0]), 32'h42);
        chk("burst_dec_b0", 32'(dec_mem[1]), 32'h11);
        chk("burst_dec_b1", 32'(dec_mem[2]), 32'h22);
        chk("burst_dec_b2", 32'(dec_mem[3]), 32'h33);
        repeat (10) tick();

        // start while busy is ignored, start in the done cycle is taken
        tx_bytes[0] = 8'h7E;
        start_txn(7'h0F, 1, -1);
        finish_txn(1, 10, 10, dur, reqs);
        chk("ignored_start_duration", 32'(dur), 32'd4800);
        chk("ignored_start_dec_addr", 32'(dec_mem[0]), 32'h1E);
        chk("ignored_start_dec_data", 32'(dec_mem[1]), 32'h7E);
        tx_bytes[0] = 8'hC3;
        start_txn(7'h44, 1, -1);
        chk("back_to_back_busy", 32'(o_busy), 32'd1);
        finish_txn(1, 10, 0, dur, reqs);
        chk("back_to_back_duration", 32'(dur), 32'd4800);
        chk("back_to_back_dec_addr", 32'(dec_mem[0]), 32'h88);
        chk("back_to_back_dec_data", 32'(dec_mem[1]), 32'hC3);

        // randomized writes, occasionally NACKed
        for (int t = 0; t < 5; t++) begin
            logic [6:0] a;
            int n;
            int nk;
            int dly;
            int sent;
            a = 7'($urandom);
            n = $urandom_range(1, 2);
            nk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
            dly = $urandom_range(1, 200);
            for (int i = 0; i < 4; i++) tx_bytes[i] = 8'($urandom);
            repeat ($urandom_range(0, 5)) tick();
            start_txn(a, n, nk);
            finish_txn(n, dly, 0, dur, reqs);
            sent = (nk < 0) ? n + 1 : nk + 1;
            chk("rand_duration", 32'(dur), 32'((8 + 36 * sent) * Q));
            chk("rand_reqs", 32'(reqs), 32'((nk < 0) ? n - 1 : ((nk < n - 1) ? nk : n - 1)));
            chk("rand_nack", 32'(o_nack), 32'(nk >= 0));
            check_decoded(a, n, nk);
        end
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
